mac_relu: RTL and testbench
===========================

MAC_RELU -- requirements
Module: mac_relu

Interface
REQ-001 Parameter MAX_TERMS, default 9, is the maximum number of products per result (3x3 kernel); legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 din  input  8  signed activation, two's complement.
REQ-005 weight  input  8  signed weight, two's complement.
REQ-006 in_valid  input  1  din/weight/in_last valid this cycle.
REQ-007 in_last  input  1  current beat is the final term of the result.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 dout_relu  output  18  ReLU'd accumulation result, feeds the bias_and_quantize stage unchanged.
REQ-010 out_valid  output  1  dout_relu holds a valid result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 err_overrun  output  1  sticky: a result was force-closed at MAX_TERMS beats without in_last.

Function
REQ-013 A beat is accepted when in_valid=1 and in_ready=1; no other input combination changes accumulator or counter.
REQ-014 Product = signed(din) x signed(weight), 16-bit signed result (range -16256..16384).
REQ-015 Accumulator: 18-bit signed; each accepted beat computes acc + product in 19 bits, saturated to [-131072, 131071].
REQ-016 Saturation is applied per beat; once clamped, later opposite-sign products move the value from the clamp point.
REQ-017 Beat counter: 4 bits, increments per accepted beat, cleared when a result closes.
REQ-018 States: IDLE (acc=0, count=0), ACCUM (≥1 beat accepted, no close), HOLD (result waiting).
REQ-019 IDLE -> ACCUM on accepted beat without close; IDLE/ACCUM -> HOLD on accepted beat with close.
REQ-020 Close condition: accepted beat with in_last=1, or accepted beat that is the MAX_TERMS-th.
REQ-021 Close at MAX_TERMS with in_last=0 sets err_overrun=1; only reset clears it.
REQ-022 On close: final = saturated(acc + product); dout_relu <= (final<0) ? 0 : final; acc <= 0; count <= 0.
REQ-023 out_valid=1 exactly while in HOLD; latency: result registered on the clock edge accepting the closing beat, visible next cycle.
REQ-024 in_ready = (state != HOLD); combinational from state only, no dependence on out_ready.
REQ-025 HOLD -> IDLE when out_ready=1; out_valid drops the following cycle; dout_relu keeps its last value until the next close.
REQ-026 One bubble per result minimum: a beat offered in the cycle out_ready releases HOLD is not accepted (in_ready=0 that cycle).
REQ-027 Single-beat results (in_last=1 in IDLE) are legal: dout_relu = max(0, product).
REQ-028 dout_relu is always in [0, 131071]; bit 17 is never 1.
REQ-029 out_ready while out_valid=0 has no effect.

Reset
REQ-030 rst_n=0 asynchronously forces: state IDLE, acc=0, count=0, dout_relu=0, out_valid=0, err_overrun=0; in_ready=1 after release.
REQ-031 Reset mid-accumulation or in HOLD discards the partial/pending result; no output pulse on release.
REQ-032 First accepted beat is possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 9 beats din=10, weight=3, last on 9th, out_ready=1 -> dout_relu=270, out_valid high one cycle, err_overrun=0.
REQ-034 9 beats din=-128, weight=-128 -> per-beat saturation, dout_relu=131071; then 1 beat din=-128, weight=127, last -> dout_relu=0.
REQ-035 3 beats (5,-7),(2,4),(1,1) last -> sum -26 -> dout_relu=0, out_valid=1.
REQ-036 out_ready=0 for 5 cycles after close -> out_valid and dout_relu stable, in_ready=0, offered beats not absorbed; out_ready=1 -> IDLE, next result independent.
REQ-037 10 beats din=1, weight=1, in_last never set -> close at beat 9 with dout_relu=9, err_overrun=1; beat 10 starts a new result.
REQ-038 Assert rst_n=0 after 4 beats, release, then single beat (6,6) last -> dout_relu=36, no stale partial sum.

Source files
------------

// File: rtl/mac_relu.sv
// mac_relu
// Multiply-accumulate of signed 8-bit activations and weights into an 18-bit
// saturating accumulator. A result closes on the beat flagged in_last, or on
// the MAX_TERMS-th beat. The closed result is passed through a ReLU and held
// until downstream takes it.
//
// Parameters
//   MAX_TERMS   maximum products per result (1..15), default 9 (3x3 kernel)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         signed activation (two's complement)
//   weight      signed weight (two's complement)
//   in_valid    din/weight/in_last valid this cycle
//   in_last     final term of the current result
//   in_ready    a beat is accepted this cycle (low while a result is held)
//   dout_relu   ReLU'd accumulation result, range 0..131071
//   out_valid   dout_relu holds a result waiting for out_ready
//   out_ready   downstream consumes the result this cycle
//   err_overrun sticky: a result was force-closed at MAX_TERMS without in_last
module mac_relu #(
    parameter int MAX_TERMS = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic [7:0]  weight,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [17:0] dout_relu,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_overrun
);

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam logic [3:0] LAST_CNT = 4'(MAX_TERMS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic signed [17:0] acc;
    logic [3:0]         count;

    logic signed [15:0] din_ext;
    logic signed [15:0] weight_ext;
    logic signed [15:0] product;
    logic signed [18:0] sum_wide;
    logic signed [17:0] acc_next;
    logic               accept;
    logic               at_limit;
    logic               close;

    // Clamp a 19-bit sum into the 18-bit signed range. Overflow is visible
    // as the top two bits disagreeing; bit 18 then carries the true sign.
    function automatic logic signed [17:0] sat18(input logic signed [18:0] v);
        if (v[18] != v[17])
            sat18 = v[18] ? 18'sh20000 : 18'sh1FFFF;
        else
            sat18 = v[17:0];
    endfunction

    function automatic logic [17:0] relu18(input logic signed [17:0] v);
        relu18 = v[17] ? 18'd0 : v;
    endfunction

    // Operands are widened to 16 bits first; the exact product always fits
    // in 16 signed bits (-16256..16384), so the truncated result is exact.
    assign din_ext    = {{(16 - DATA_W){din[DATA_W-1]}}, din};
    assign weight_ext = {{(16 - COEF_W){weight[COEF_W-1]}}, weight};
    assign product    = din_ext * weight_ext;

    assign sum_wide = {acc[17], acc} + {{3{product[15]}}, product};
    assign acc_next = sat18(sum_wide);

    // Ready depends on state only, so a release cycle is always a bubble.
    assign in_ready = (state != HOLD);
    assign accept   = in_valid & in_ready;
    assign at_limit = (count == LAST_CNT);
    assign close    = accept & (in_last | at_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            dout_relu   <= '0;
            out_valid   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (close) begin
                        dout_relu <= relu18(acc_next);
                        acc       <= '0;
                        count     <= '0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                        // close without in_last can only come from the limit
                        if (!in_last)
                            err_overrun <= 1'b1;
                    end else if (accept) begin
                        acc   <= acc_next;
                        count <= count + 4'd1;
                        state <= ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_relu.sv
// Self-checking bench for mac_relu: directed steps in one initial block,
// expected results queued when the closing beat is driven and compared when
// the DUT hands a result over (out_valid && out_ready).
module tb_mac_relu;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic [7:0]  weight;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [17:0] dout_relu;
    logic        out_valid;
    logic        out_ready;
    logic        err_overrun;

    typedef struct {
        logic [17:0] dout;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mac_relu #(.MAX_TERMS(9)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .weight      (weight),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .dout_relu   (dout_relu),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_overrun (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [17:0] d, input logic e);
        exp_t x;
        x.dout = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    // One clock: scoreboard compare at the falling edge, return 1ns after the
    // next rising edge so inputs can be changed safely.
    task automatic tick();
        exp_t x;
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(dout_relu), 32'hFFFF_FFFF);
            end else begin
                x = sb.pop_front();
                chk("dout_relu", 32'(dout_relu), 32'(x.dout));
                chk("err_overrun", 32'(err_overrun), 32'(x.err));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer a beat and hold it until it is accepted (bounded).
    task automatic send(input logic signed [7:0] d, input logic signed [7:0] w, input logic last);
        int n;
        din      = d;
        weight   = w;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20)
            chk("ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        weight    = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout_relu), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err_overrun), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // 9 x (10*3), last on 9th -> 270, one-cycle out_valid
        for (int i = 0; i < 8; i++) send(8'sd10, 8'sd3, 1'b0);
        push(18'd270, 1'b0);
        send(8'sd10, 8'sd3, 1'b1);
        chk("s1_out_valid", 32'(out_valid), 32'd1);
        chk("s1_in_ready_hold", 32'(in_ready), 32'd0);
        tick();
        chk("s1_out_valid_drop", 32'(out_valid), 32'd0);
        chk("s1_in_ready_idle", 32'(in_ready), 32'd1);

        // (5,-7),(2,4),(1,1) -> -26 -> ReLU 0
        send(8'sd5, -8'sd7, 1'b0);
        send(8'sd2, 8'sd4, 1'b0);
        push(18'd0, 1'b0);
        send(8'sd1, 8'sd1, 1'b1);
        chk("s3_out_valid", 32'(out_valid), 32'd1);
        tick();

        // downstream stall: result held, offered beats not absorbed
        out_ready = 1'b0;
        send(8'sd3, 8'sd4, 1'b0);
        push(18'd42, 1'b0);
        send(8'sd5, 8'sd6, 1'b1);
        din = 8'sd100; weight = 8'sd100; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_dout", 32'(dout_relu), 32'd42);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_dout_kept", 32'(dout_relu), 32'd42);
        push(18'd6, 1'b0);
        send(8'sd2, 8'sd3, 1'b1);
        tick();

        // 9 x (-128*-128) saturates, force-closed at the limit
        for (int i = 0; i < 8; i++) send(-8'sd128, -8'sd128, 1'b0);
        push(18'd131071, 1'b1);
        send(-8'sd128, -8'sd128, 1'b0);
        chk("sat_err_set", 32'(err_overrun), 32'd1);
        tick();
        push(18'd0, 1'b1);
        send(-8'sd128, 8'sd127, 1'b1);
        tick();

        // 10 x (1*1) no last: close at 9, 10th starts a new result
        for (int i = 0; i < 8; i++) send(8'sd1, 8'sd1, 1'b0);
        push(18'd9, 1'b1);
        send(8'sd1, 8'sd1, 1'b0);
        send(8'sd1, 8'sd1, 1'b0);
        push(18'd2, 1'b1);
        send(8'sd1, 8'sd1, 1'b1);
        tick();

        // reset mid-accumulation discards the partial sum
        for (int i = 0; i < 4; i++) send(8'sd7, 8'sd7, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_err_clear", 32'(err_overrun), 32'd0);
        chk("midrst_dout", 32'(dout_relu), 32'd0);
        tick();
        rst_n = 1'b1;
        push(18'd36, 1'b0);
        send(8'sd6, 8'sd6, 1'b1);
        chk("single_out_valid", 32'(out_valid), 32'd1);
        tick();

        // reset while holding: no output pulse after release
        out_ready = 1'b0;
        send(8'sd9, 8'sd9, 1'b1);
        chk("hold_before_rst", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("hold_rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("hold_rst_no_pulse", 32'(out_valid), 32'd0);
        chk("hold_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
